// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, prefetches 16-bit instructions into a small FIFO and presents the head to Decode.
// Optional FETCHQ_BYPASS_EN: when the queue is empty, a returning word is forwarded to Decode in the same cycle.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [15:0]            imem_addr,
    input  logic                   imem_ack,
    input  logic [15:0]            imem_rdata,
    input  logic                   redirect,
    input  logic [15:0]            redirect_pc,
    input  logic                   stall,
    output logic                   valid,
    output logic [15:0]            ir,
    output logic [15:0]            old_pc,
    output logic [15:0]            new_pc,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [15:0]   fetchPcReg;
    logic [15:0]   dropAddrReg;
    logic          dropReg;
    logic [PW-1:0] rdPtrReg;
    logic [PW-1:0] wrPtrReg;
    logic [CW-1:0] countReg;
    logic [15:0]   pcMem [DEPTH];
    logic [15:0]   irMem [DEPTH];

    logic        ackTake;
    logic        fifoValid;
    logic        bypassHit;
    logic        doPush;
    logic        doPop;
    logic [15:0] headPc;
    logic [15:0] headIr;

    // While a stale read is being drained the bus stays on its old address regardless of queue state.
    always_comb begin
        imem_req  = reset && (dropReg || (countReg < CW'(DEPTH)));
        imem_addr = dropReg ? dropAddrReg : fetchPcReg;
        ackTake   = imem_req && imem_ack;
        fifoValid = (countReg != '0);
`ifdef FETCHQ_BYPASS_EN
        bypassHit = ackTake && !dropReg && !redirect && !fifoValid;
`else
        bypassHit = 1'b0;
`endif
        doPush    = ackTake && !dropReg && !redirect && !(bypassHit && !stall);
        doPop     = fifoValid && !stall && !redirect;
    end

    assign headPc = pcMem[rdPtrReg];
    assign headIr = irMem[rdPtrReg];
    assign count  = countReg;

    always_comb begin
        valid  = 1'b0;
        old_pc = 16'h0000;
        ir     = 16'h0000;
        if (fifoValid) begin
            valid  = 1'b1;
            old_pc = headPc;
            ir     = headIr;
        end else if (bypassHit) begin
            valid  = 1'b1;
            old_pc = imem_addr;
            ir     = imem_rdata;
        end
        new_pc = old_pc + 16'd2;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetchPcReg  <= RESET_PC;
            dropAddrReg <= RESET_PC;
            dropReg     <= 1'b0;
            rdPtrReg    <= '0;
            wrPtrReg    <= '0;
            countReg    <= '0;
        end else if (redirect) begin
            fetchPcReg <= redirect_pc;
            rdPtrReg   <= '0;
            wrPtrReg   <= '0;
            countReg   <= '0;
            // A read still in flight must be allowed to finish, then thrown away.
            if (dropReg) begin
                dropReg <= !imem_ack;
            end else if (imem_req && !imem_ack) begin
                dropReg     <= 1'b1;
                dropAddrReg <= fetchPcReg;
            end
        end else begin
            if (dropReg) begin
                if (imem_ack) begin
                    dropReg <= 1'b0;
                end
            end else if (ackTake) begin
                fetchPcReg <= fetchPcReg + 16'd2;
            end
            if (doPush) begin
                wrPtrReg <= wrPtrReg + PW'(1);
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + PW'(1);
            end
            if (doPush && !doPop) begin
                countReg <= countReg + CW'(1);
            end else if (!doPush && doPop) begin
                countReg <= countReg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            pcMem[wrPtrReg] <= imem_addr;
            irMem[wrPtrReg] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-level reference model checked every cycle, directed scenarios plus random traffic.
module tb_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [15:0] RPC   = 16'h0000;
`ifdef FETCHQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        stall = 1'b0;
    logic        valid;
    logic [15:0] ir;
    logic [15:0] old_pc;
    logic [15:0] new_pc;
    logic [2:0]  count;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .valid(valid), .ir(ir), .old_pc(old_pc), .new_pc(new_pc), .count(count)
    );

    always #5 clk = ~clk;

    // Reference state: the queue holds {pc, word} pairs in program order.
    logic [31:0] mq[$];
    logic [15:0] mFetch;
    logic [15:0] mDropAddr;
    bit          mDrop;
    int          memWait;
    int          memLat;
    bit          inTxn;
    int          nVec;
    int          nMis;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit stl, input bit rdr, input logic [15:0] rpc);
        bit          mReq;
        bit          byp;
        bit          mValid;
        logic [15:0] mAddr;
        logic [15:0] mOld;
        logic [15:0] mIr;
        @(negedge clk);
        reset       = rst;
        stall       = stl;
        redirect    = rdr;
        redirect_pc = rpc;
        #1;
        if (!imem_req) begin
            inTxn      = 1'b0;
            imem_ack   = 1'b0;
            imem_rdata = 16'($urandom);
        end else begin
            if (!inTxn) begin
                inTxn   = 1'b1;
                memWait = memLat;
            end
            if (memWait == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr ^ 16'hA5A5;
                inTxn      = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 16'($urandom);
                memWait--;
            end
        end
        #1;
        mReq  = rst && (mDrop || mq.size() < DEPTH);
        mAddr = mDrop ? mDropAddr : mFetch;
        byp   = BYP && (mq.size() == 0) && mReq && imem_ack && !mDrop && !rdr;
        if (mq.size() > 0) begin
            mValid = 1'b1;
            mOld   = mq[0][31:16];
            mIr    = mq[0][15:0];
        end else if (byp) begin
            mValid = 1'b1;
            mOld   = mAddr;
            mIr    = imem_rdata;
        end else begin
            mValid = 1'b0;
            mOld   = 16'h0000;
            mIr    = 16'h0000;
        end
        chk("imem_req", 16'(imem_req), 16'(mReq));
        chk("imem_addr", imem_addr, mAddr);
        chk("valid", 16'(valid), 16'(mValid));
        chk("ir", ir, mIr);
        chk("old_pc", old_pc, mOld);
        chk("new_pc", new_pc, mOld + 16'd2);
        chk("count", 16'(count), 16'(mq.size()));

        if (!rst) begin
            mq.delete();
            mFetch = RPC;
            mDrop  = 1'b0;
        end else if (rdr) begin
            mq.delete();
            if (mDrop) begin
                if (imem_ack) mDrop = 1'b0;
            end else if (mReq && !imem_ack) begin
                mDrop     = 1'b1;
                mDropAddr = mAddr;
            end
            mFetch = rpc;
        end else if (mDrop) begin
            if (imem_ack) mDrop = 1'b0;
        end else begin
            if (mValid && !stl) $display("decode pc=%h ir=%h", mOld, mIr);
            if (mq.size() > 0 && !stl) void'(mq.pop_front());
            if (mReq && imem_ack) begin
                mFetch = mFetch + 16'd2;
                if (!(byp && !stl)) mq.push_back({mAddr, imem_rdata});
            end
        end
    endtask

    initial begin
        bit found;
        nVec = 0; nMis = 0; memLat = 0; memWait = 0; inTxn = 1'b0;
        mq.delete(); mFetch = RPC; mDrop = 1'b0; mDropAddr = RPC;
        @(posedge clk);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 16'h0);
        chk("rst_valid", 16'(valid), 16'h0);
        chk("rst_req", 16'(imem_req), 16'h0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_new_pc", new_pc, 16'h0002);
        chk("rst_count", 16'(count), 16'h0);

        // Stall from reset release: queue saturates, then drains in order.
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 16'h0);
        chk("sat_count", 16'(count), 16'h4);
        chk("sat_req", 16'(imem_req), 16'h0);
        chk("sat_old_pc", old_pc, 16'h0000);
        chk("sat_ir", ir, 16'hA5A5);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 16'h0);
            chk("drain_pc", old_pc, 16'(2 * k));
        end

        // Zero-wait stream from a fresh reset.
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        chk("s1_req", 16'(imem_req), 16'h1);
        chk("s1_addr", imem_addr, 16'h0000);
        chk("s1_valid", 16'(valid), 16'(BYP));
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        chk("s2_addr", imem_addr, 16'h0002);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        chk("s3_addr", imem_addr, 16'h0004);
        chk("s3_old_pc", old_pc, BYP ? 16'h0004 : 16'h0002);
        chk("s3_ir", ir, (BYP ? 16'h0004 : 16'h0002) ^ 16'hA5A5);
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 16'h0);

        // Redirect with a full queue and nothing outstanding.
        repeat (8) cycle(1'b1, 1'b1, 1'b0, 16'h0);
        cycle(1'b1, 1'b1, 1'b1, 16'h0100);
        cycle(1'b1, 1'b1, 1'b0, 16'h0);
        chk("rd1_count", 16'(count), 16'h0);
        chk("rd1_addr", imem_addr, 16'h0100);
        chk("rd1_valid", 16'(valid), 16'(BYP));
        cycle(1'b1, 1'b1, 1'b0, 16'h0);
        chk("rd2_count", 16'(count), 16'h1);
        chk("rd2_old_pc", old_pc, 16'h0100);
        chk("rd2_new_pc", new_pc, 16'h0102);

        // Redirect while a slow read is outstanding: old address held, word dropped.
        repeat (8) cycle(1'b1, 1'b1, 1'b0, 16'h0);
        memLat = 3;
        cycle(1'b1, 1'b1, 1'b1, 16'h0010);
        cycle(1'b1, 1'b1, 1'b0, 16'h0);
        chk("dr_req", 16'(imem_req), 16'h1);
        chk("dr_addr0", imem_addr, 16'h0010);
        cycle(1'b1, 1'b1, 1'b1, 16'h0200);
        chk("dr_addr1", imem_addr, 16'h0010);
        cycle(1'b1, 1'b1, 1'b0, 16'h0);
        chk("dr_addr2", imem_addr, 16'h0010);
        cycle(1'b1, 1'b1, 1'b0, 16'h0);
        chk("dr_addr3", imem_addr, 16'h0010);
        cycle(1'b1, 1'b1, 1'b0, 16'h0);
        chk("dr_next_addr", imem_addr, 16'h0200);
        chk("dr_count", 16'(count), 16'h0);
        chk("dr_valid", 16'(valid), 16'h0);
        memLat = 0;
        repeat (6) cycle(1'b1, 1'b0, 1'b0, 16'h0);

        // PC wrap at FFFE.
        repeat (8) cycle(1'b1, 1'b1, 1'b0, 16'h0);
        cycle(1'b1, 1'b1, 1'b1, 16'hFFFE);
        cycle(1'b1, 1'b1, 1'b0, 16'h0);
        chk("wr_addr", imem_addr, 16'hFFFE);
        cycle(1'b1, 1'b1, 1'b0, 16'h0);
        chk("wr_old_pc", old_pc, 16'hFFFE);
        chk("wr_new_pc", new_pc, 16'h0000);
        chk("wr_addr2", imem_addr, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        chk("wr2_old_pc", old_pc, 16'h0000);
        chk("wr2_new_pc", new_pc, 16'h0002);

        // Reset in the middle of an outstanding read with two entries queued.
        memLat = 3;
        found  = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 16'h0);
            if (count == 3'd2 && imem_req && !imem_ack) found = 1'b1;
        end
        chk("mid_found", 16'(found), 16'h1);
        cycle(1'b0, 1'b1, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        chk("mr_valid", 16'(valid), 16'h0);
        chk("mr_count", 16'(count), 16'h0);
        chk("mr_req", 16'(imem_req), 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        chk("mr_restart_req", 16'(imem_req), 16'h1);
        chk("mr_restart_addr", imem_addr, RPC);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            bit          rst;
            bit          stl;
            bit          rdr;
            logic [15:0] rpc;
            memLat = (n % 400 < 200) ? 0 : int'($urandom_range(0, 3));
            rst    = ($urandom_range(0, 199) != 0);
            stl    = ($urandom_range(0, 9) < 3);
            rdr    = ($urandom_range(0, 19) == 0);
            rpc    = ($urandom_range(0, 3) == 0) ? 16'hFFFC : (16'($urandom) & 16'hFFFE);
            cycle(rst, stl, rdr, rpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
